// File: rtl/seg_msg_scheduler_pkg.sv
// Shared types and helpers for the seven-segment message scheduler.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } seg_state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Width of the encoded requester index, never below one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_msg_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request searching upward from last+1.
module rr_arbiter
    import seg_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = owner_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic          found;
    int            pos;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(last) + k) % NREQ;
            idx = IW'(pos);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/seg_msg_scheduler.sv
// Round-robin time-sharing of the two-digit display among NREQ requesters.
// Optional urgent preemption by requester 0 is enabled with `define SEG_PREEMPT_EN.
module seg_msg_scheduler
    import seg_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TICK_DIV = 50000,
    parameter int DUR_W    = 8,
    localparam int OW      = owner_w(NREQ)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [DUR_W*NREQ-1:0]   req_dur,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              disp_x,
    output logic                    disp_blank,
    output logic [OW-1:0]           owner,
    output logic                    busy
);

    localparam int PW = $clog2(TICK_DIV);

    seg_state_t       state;
    logic [OW-1:0]    last;
    logic [PW-1:0]    presc;
    logic [DUR_W-1:0] dcnt;

    logic [NREQ-1:0]  gnt;
    logic [OW-1:0]    gnt_idx;
    logic [7:0]       sel_data;
    logic [DUR_W-1:0] sel_dur;
    logic [DUR_W-1:0] sel_dwell;
    logic [DUR_W-1:0] urg_dwell;
    logic             wrap;
    logic             xfer;
    logic             preempt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .last    (last),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_data = SEG_BLANK;
        sel_dur  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == OW'(i)) begin
                sel_data = req_data[8*i +: 8];
                sel_dur  = req_dur[DUR_W*i +: DUR_W];
            end
        end
    end

    // A zero dwell still shows the message for one tick.
    assign sel_dwell = (sel_dur == '0) ? DUR_W'(1) : sel_dur;
    assign urg_dwell = (req_dur[DUR_W-1:0] == '0) ? DUR_W'(1) : req_dur[DUR_W-1:0];

    assign wrap = (presc == PW'(TICK_DIV - 1));
    assign xfer = (state == IDLE) && (|gnt) && !clr;

`ifdef SEG_PREEMPT_EN
    assign preempt = (state == SHOW) && (owner != '0) && req_valid[0] && !clr;
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        req_ready = '0;
        if (!clr) begin
            if (state == IDLE)
                req_ready = gnt;
            else if (preempt)
                req_ready = NREQ'(1);
        end
    end

    // FSM, prescaler, dwell counter and registered display outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            disp_x     <= SEG_BLANK;
            disp_blank <= 1'b1;
            owner      <= '0;
            busy       <= 1'b0;
            last       <= OW'(NREQ - 1);
            presc      <= '0;
            dcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        disp_x     <= sel_data;
                        dcnt       <= sel_dwell;
                        owner      <= gnt_idx;
                        last       <= gnt_idx;
                        presc      <= '0;
                        disp_blank <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHOW;
                    end
                end
                SHOW: begin
                    if (preempt) begin
                        disp_x <= req_data[7:0];
                        dcnt   <= urg_dwell;
                        owner  <= '0;
                        last   <= '0;
                        presc  <= '0;
                    end else if (wrap) begin
                        presc <= '0;
                        if (dcnt <= DUR_W'(1)) begin
                            dcnt       <= '0;
                            disp_blank <= 1'b1;
                            state      <= GAP;
                        end else begin
                            dcnt <= dcnt - DUR_W'(1);
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                GAP: begin
                    if (wrap) begin
                        presc <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_msg_scheduler.sv
// Directed self-checking bench for seg_msg_scheduler with NREQ=4, TICK_DIV=4, DUR_W=8.
module tb_seg_msg_scheduler;

    localparam int NREQ     = 4;
    localparam int TICK_DIV = 4;
    localparam int DUR_W    = 8;

    logic        clk;
    logic        clr;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [31:0] req_dur;
    logic [3:0]  req_ready;
    logic [7:0]  disp_x;
    logic        disp_blank;
    logic [1:0]  owner;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    seg_msg_scheduler #(.NREQ(NREQ), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_dur    (req_dur),
        .req_ready  (req_ready),
        .disp_x     (disp_x),
        .disp_blank (disp_blank),
        .owner      (owner),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        clr       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic measure_show(output int n);
        n = 0;
        while (disp_blank === 1'b0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic measure_gap(output int n);
        n = 0;
        while (busy === 1'b1 && disp_blank === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr       = 1'b1;
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL reset_ready_in_clr: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (disp_blank !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_blank: got %b expected 1", disp_blank);
        end
        n_cmp++;
        if (disp_x !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL reset_x: got %h expected 00", disp_x);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
        end
        n_cmp++;
        if (owner !== 2'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_owner: got %0d expected 0", owner);
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        @(negedge clk);
        req_data  = 32'h005A0000;
        req_dur   = 32'h00030000;
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("[TB] FAIL single_ready: got %b expected 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        req_data  = 32'hFFFFFFFF;
        req_dur   = 32'h09090909;
        #1;
        n_cmp++;
        if (disp_x !== 8'h5A) begin
            n_bad++;
            $display("[TB] FAIL single_x: got %h expected 5a", disp_x);
        end
        n_cmp++;
        if (owner !== 2'd2 || busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL single_owner_busy: got owner %0d busy %b expected 2 1", owner, busy);
        end
        measure_show(n);
        n_cmp++;
        if (n !== 12) begin
            n_bad++;
            $display("[TB] FAIL single_show_len: got %0d expected 12", n);
        end
        n_cmp++;
        if (disp_x !== 8'h5A) begin
            n_bad++;
            $display("[TB] FAIL single_gap_x_hold: got %h expected 5a", disp_x);
        end
        measure_gap(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("[TB] FAIL single_gap_len: got %0d expected 4", n);
        end
        n_cmp++;
        if (busy !== 1'b0 || disp_blank !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL single_idle: got busy %b blank %b expected 0 1", busy, disp_blank);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_oh[5];
        int ng;
        int cyc;
        int gprev;
        do_reset();
        req_data = 32'h13121110;
        req_dur  = 32'h01010101;
`ifdef SEG_PREEMPT_EN
        exp_oh[0] = 4'b0010; exp_oh[1] = 4'b0100; exp_oh[2] = 4'b1000;
        exp_oh[3] = 4'b0010; exp_oh[4] = 4'b0100;
        @(negedge clk);
        req_valid = 4'b1110;
`else
        exp_oh[0] = 4'b0001; exp_oh[1] = 4'b0010; exp_oh[2] = 4'b0100;
        exp_oh[3] = 4'b1000; exp_oh[4] = 4'b0001;
        @(negedge clk);
        req_valid = 4'b1111;
`endif
        ng    = 0;
        cyc   = 0;
        gprev = 0;
        while (ng < 5 && cyc < 200) begin
            #1;
            if (req_ready !== 4'b0000) begin
                n_cmp++;
                if (req_ready !== exp_oh[ng]) begin
                    n_bad++;
                    $display("[TB] FAIL fair_grant%0d: got %b expected %b", ng, req_ready, exp_oh[ng]);
                end
                if (ng > 0) begin
                    n_cmp++;
                    if (cyc - gprev !== 9) begin
                        n_bad++;
                        $display("[TB] FAIL fair_spacing%0d: got %0d expected 9", ng, cyc - gprev);
                    end
                end
                gprev = cyc;
                ng++;
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (ng !== 5) begin
            n_bad++;
            $display("[TB] FAIL fair_count: got %0d grants expected 5", ng);
        end
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_dwell_limits();
        int n;
        do_reset();
        @(negedge clk);
        req_data  = 32'hC3000A00;
        req_dur   = 32'hFF000000;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        measure_show(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("[TB] FAIL zero_dwell_len: got %0d expected 4", n);
        end
        wait_idle();
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        n_cmp++;
        if (owner !== 2'd3 || disp_x !== 8'hC3) begin
            n_bad++;
            $display("[TB] FAIL max_dwell_load: got owner %0d x %h expected 3 c3", owner, disp_x);
        end
        measure_show(n);
        n_cmp++;
        if (n !== 1020) begin
            n_bad++;
            $display("[TB] FAIL max_dwell_len: got %0d expected 1020", n);
        end
        wait_idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        @(negedge clk);
        req_data  = 32'h00770000;
        req_dur   = 32'h00030000;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        clr       = 1'b1;
        req_valid = 4'b0101;
        #1;
        n_cmp++;
        if (disp_blank !== 1'b1 || disp_x !== 8'h00 || busy !== 1'b0 || owner !== 2'd0) begin
            n_bad++;
            $display("[TB] FAIL midreset_outputs: got blank %b x %h busy %b owner %0d expected 1 00 0 0",
                     disp_blank, disp_x, busy, owner);
        end
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL midreset_ready_in_clr: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL midreset_next_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_preempt();
        int n;
        do_reset();
        @(negedge clk);
        req_data  = 32'h00001199;
        req_dur   = 32'h00000502;
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        req_valid = 4'b0001;
        #1;
`ifdef SEG_PREEMPT_EN
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL preempt_ready: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (disp_x !== 8'h99 || owner !== 2'd0) begin
            n_bad++;
            $display("[TB] FAIL preempt_load: got x %h owner %0d expected 99 0", disp_x, owner);
        end
        measure_show(n);
        n_cmp++;
        if (n !== 8) begin
            n_bad++;
            $display("[TB] FAIL preempt_show_len: got %0d expected 8", n);
        end
        measure_gap(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("[TB] FAIL preempt_gap_len: got %0d expected 4", n);
        end
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL preempt_no_requeue: got ready %b busy %b expected 0000 0", req_ready, busy);
        end
`else
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("[TB] FAIL nopreempt_ready: got %b expected 0000", req_ready);
        end
        measure_show(n);
        n_cmp++;
        if (n !== 14) begin
            n_bad++;
            $display("[TB] FAIL nopreempt_show_rest: got %0d expected 14", n);
        end
        measure_gap(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("[TB] FAIL nopreempt_gap_len: got %0d expected 4", n);
        end
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("[TB] FAIL nopreempt_late_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++;
        if (disp_x !== 8'h99) begin
            n_bad++;
            $display("[TB] FAIL nopreempt_late_x: got %h expected 99", disp_x);
        end
        wait_idle();
`endif
    endtask

    initial begin
        clr       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_dur   = '0;
        $display("[TB] starting seg_msg_scheduler bench");
        test_reset();
        test_single();
        test_fairness();
        test_dwell_limits();
        test_mid_reset();
        test_preempt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_msg_scheduler.md
# seg_msg_scheduler

Time-shares the two-digit seven-segment display between several requesters. Each requester offers an 8-bit display byte and a dwell time over a valid/ready handshake. A round-robin arbiter picks one message, holds it on the display for the requested number of ticks, then blanks the display for one tick. The block sits between the application logic and the two-digit display driver, whose `x[7:0]` input it feeds.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `TICK_DIV`, default 50000: clk cycles per dwell tick, minimum 2.
- `DUR_W`, default 8: width of the dwell field.
- `clk` in 1: clock, rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `req_valid` in NREQ: requester i holds a message.
- `req_data` in 8*NREQ: display byte for requester i, at bits `[8i+7:8i]`.
- `req_dur` in DUR_W*NREQ: dwell in ticks for requester i. A value of 0 is treated as 1.
- `req_ready` out NREQ: one-hot accept strobe. A transfer happens on a clk edge where `req_valid[i]` and `req_ready[i]` are both 1.
- `disp_x` out 8: byte to the display driver.
- `disp_blank` out 1: driver must blank all digits when this is 1.
- `owner` out clog2(NREQ): index of the requester currently shown.
- `busy` out 1: high in SHOW or GAP.

## Operation
- States: IDLE, SHOW, GAP.
- Reset values:
  - state IDLE
  - `disp_x` = 0x00
  - `disp_blank` = 1
  - `owner` = 0
  - `busy` = 0
  - `req_ready` = 0
  - round-robin pointer `last` = NREQ-1, so requester 0 has first priority
  - prescaler and dwell counter = 0
- IDLE:
  - `req_ready` is combinational. It is one-hot for the round-robin winner: the first asserted `req_valid` searching from `last+1` upward, with wrap-around.
  - It is all-zero when no request is valid.
  - On the transfer edge:
    - latch `req_data` into `disp_x` and the dwell into the counter
    - set `owner` and `last` to the winner
    - clear the prescaler
    - go to SHOW
- SHOW:
  - `disp_blank` = 0.
  - The prescaler counts 0..TICK_DIV-1. Each wrap decrements the dwell counter.
  - When the counter reaches 0 on a wrap, go to GAP and clear the prescaler.
  - `req_ready` = 0, except for preemption (see Configuration).
- GAP:
  - `disp_blank` = 1 and `disp_x` holds its value.
  - After exactly TICK_DIV cycles, go to IDLE.
- The round-robin pointer advances only on a transfer.
- A requester that drops `req_valid` before it is granted loses its turn with no side effects.
- Data is sampled only on the transfer edge. Later changes to `req_data` or `req_dur` do not affect the message being shown.
- Asserting `clr` mid-message aborts it immediately. All outputs return to their reset values and no `req_ready` is emitted while `clr` is high.

## Timing
- Grant latency: `req_ready` is high in the same cycle as `req_valid` when the block is IDLE. `disp_x` is updated on the following edge.
- SHOW lasts exactly max(dur,1)*TICK_DIV cycles.
- GAP lasts exactly TICK_DIV cycles.
- The earliest next grant is in the cycle after GAP ends. Back-to-back message period = (max(dur,1)+1)*TICK_DIV + 1 cycles.
- If several requests are valid simultaneously, exactly one is granted per IDLE visit.
- dur = 2^DUR_W-1 must count down with no overflow.

## Configuration
- `SEG_PREEMPT_EN` defined:
  - Requester 0 is urgent.
  - In SHOW with `owner` ≠ 0, `req_valid[0]` raises `req_ready[0]` combinationally.
  - On that edge, requester 0's message is loaded, the dwell restarts, `owner` and `last` become 0, and the block stays in SHOW.
  - The preempted message is dropped and is not re-queued. There is no GAP inserted.
  - Requester 0 never preempts itself.
- Not defined: requester 0 is an ordinary round-robin participant and SHOW is never interrupted.

## Structure
- Package `seg_pkg`:
  - state enum (IDLE/SHOW/GAP)
  - `SEG_BLANK` constant (0x00 reset byte)
  - width helper for `owner`
- Sub-module `rr_arbiter`: combinational round-robin, parameterized by NREQ. Inputs `req[NREQ]` and `last`; outputs one-hot `gnt` and encoded `gnt_idx`.
- The top level contains the FSM, the prescaler, the dwell counter and the output registers.

## Test plan
All scenarios use NREQ=4, TICK_DIV=4, DUR_W=8.
- Reset: hold `clr`, then release -> `disp_blank`=1, `disp_x`=0x00, `busy`=0, `req_ready`=0, with no requests pending.
- Single request: req 2 with data 0x5A, dur 3 -> `req_ready`=0b0100 for 1 cycle. Then `disp_x`=0x5A and `disp_blank`=0 for 12 cycles, blank for 4 cycles, then IDLE.
- Fairness: all four requesters valid continuously with dur 1 -> grant order 0,1,2,3,0. Each grant is spaced 9 cycles apart.
- Zero dwell and max dwell:
  - dur 0 -> shown for 4 cycles
  - dur 255 -> shown for 1020 cycles, with the counter not wrapping
- Mid-message reset: `clr` pulsed 5 cycles into SHOW -> outputs return to reset values that cycle. The next grant goes to requester 0.
- Preemption (`SEG_PREEMPT_EN`): req 1 showing 0x11 with dur 5; raise req 0 with 0x99 and dur 2 after 6 cycles -> `req_ready[0]` goes high that cycle, then `disp_x`=0x99 for 8 cycles. Req 1 is not re-served. Without the macro, req 0 waits for GAP to end.
